// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg -- shared definitions for the HD44780-style LCD write controller.
//
// Contents: controller state enum, io_lcd_o bit positions, the opcodes that
// need the long execution wait, the power-up init table and small helpers.
//
// Build option: define LCD_INIT_EN to include the power-up init states and
// the init table; without it they are left out entirely.
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_HOLD      = 3'd3,
        ST_EXEC      = 3'd4
`ifdef LCD_INIT_EN
        ,
        ST_INIT_WAIT = 3'd5,
        ST_INIT_LOAD = 3'd6
`endif
    } lcd_state_e;

    // Bit positions inside the packed io_lcd_o bus; all other bits are 0.
    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    // Instructions that need the long execution wait (clear / return home).
    localparam logic [7:0] OP_CLEAR     = 8'h01;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_HOME_ALT  = 8'h03;

`ifdef LCD_INIT_EN
    // Power-up sequence: 8-bit/2-line, display on, clear, entry mode.
    // Entry 0 is sent first.
    localparam int INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {8'h06, 8'h01, 8'h0C, 8'h38};
`endif

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
    endfunction

    // ON is always 1 and RW always 0 (write-only controller).
    function automatic logic [31:0] pack_io(input logic en, input logic rs, input logic [7:0] data);
        logic [31:0] io;
        io             = '0;
        io[LCD_ON_BIT] = 1'b1;
        io[LCD_EN_BIT] = en;
        io[LCD_RS_BIT] = rs;
        io[LCD_RW_BIT] = 1'b0;
        io[7:0]        = data;
        return io;
    endfunction

endpackage

// File: rtl/lcd_if.sv
// -----------------------------------------------------------------------------
// lcd_if -- command request channel into the LCD controller.
//
// Signals (names follow the controller's point of view):
//   cmd_valid_i  sender has a request
//   cmd_rs_i     0 = instruction, 1 = data
//   cmd_data_i   byte to write
//   cmd_ready_o  controller can accept a request this cycle
//   busy_o       inverse of cmd_ready_o
// Modports: master = request sender, slave = lcd_ctrl.
// -----------------------------------------------------------------------------
interface lcd_if;
    logic       cmd_valid_i;
    logic       cmd_rs_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ready_o;
    logic       busy_o;

    modport master (
        output cmd_valid_i, cmd_rs_i, cmd_data_i,
        input  cmd_ready_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_rs_i, cmd_data_i,
        output cmd_ready_o, busy_o
    );
endinterface

// File: rtl/lcd_delay_cnt.sv
// -----------------------------------------------------------------------------
// lcd_delay_cnt -- loadable down-counter with a done flag.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         load load_val_i this cycle (wins over counting)
//   load_val_i     value to load; a phase of N cycles loads N-1
//   done_o         counter is at zero
// The counter sits at RST_VAL while reset is held and stops at zero.
// -----------------------------------------------------------------------------
module lcd_delay_cnt #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d -- no latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl -- write-only controller for a parallel character LCD.
//
// Takes one request (RS + byte) at a time over lcd_if and plays it out on the
// packed LCD pins: RS/DATA set up, EN pulse, RS/DATA hold, then an execution
// wait (long for clear/home instructions) before the next request is taken.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   cmd_if    lcd_if.slave request channel (valid/ready/rs/data/busy)
//   io_lcd_o  bit31 ON, bit10 EN, bit9 RS, bit8 RW, bits7:0 DATA, others 0
//
// Build option LCD_INIT_EN: after reset wait POWERUP_CYC cycles, then send the
// init table from lcd_pkg before first reporting ready. Without it the
// controller comes out of reset directly in IDLE.
// -----------------------------------------------------------------------------
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int POWERUP_CYC   = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lcd_if.slave        cmd_if,
    output logic [31:0] io_lcd_o
);

    // One counter serves every phase, so it is sized for the longest one.
    localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, EXEC_CYC)),
                                     max_int(LONG_EXEC_CYC, POWERUP_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

`ifdef LCD_INIT_EN
    localparam lcd_state_e       RESET_STATE = ST_INIT_WAIT;
    localparam logic [CNT_W-1:0] CNT_RST_VAL = CNT_W'(POWERUP_CYC - 1);
`else
    localparam lcd_state_e       RESET_STATE = ST_IDLE;
    localparam logic [CNT_W-1:0] CNT_RST_VAL = '0;
`endif

    lcd_state_e       state_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
`ifdef LCD_INIT_EN
    logic [1:0]       init_idx_q;
    logic             init_done_q;
`endif

    logic             cmd_ready;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    // Ready is a decode of the state register; gating with rst_i keeps it low
    // for the whole time reset is held, even though IDLE is the reset state of
    // the no-init build.
    assign cmd_ready        = (state_q == ST_IDLE) && !rst_i;
    assign accept           = cmd_ready && cmd_if.cmd_valid_i;
    assign cmd_if.cmd_ready_o = cmd_ready;
    assign cmd_if.busy_o      = !cmd_ready;

    assign io_lcd_o = pack_io(en_q, rs_q, data_q);

    // Counter reload: each phase loads its length minus one on the cycle the
    // FSM moves into it, so the phase lasts exactly its length.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
                end
            end
`ifdef LCD_INIT_EN
            ST_INIT_LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = SETUP_LD;
            end
`endif
            default: ;
        endcase
    end

    lcd_delay_cnt #(
        .WIDTH   (CNT_W),
        .RST_VAL (CNT_RST_VAL)
    ) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RESET_STATE;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
`ifdef LCD_INIT_EN
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rs_q    <= cmd_if.cmd_rs_i;
                        data_q  <= cmd_if.cmd_data_i;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        en_q    <= 1'b1;
                        state_q <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_done) begin
                        en_q    <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_done) begin
`ifdef LCD_INIT_EN
                        if (!init_done_q && (init_idx_q != 2'(INIT_LEN - 1))) begin
                            init_idx_q <= init_idx_q + 2'd1;
                            state_q    <= ST_INIT_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef LCD_INIT_EN
                ST_INIT_WAIT: begin
                    if (cnt_done) begin
                        state_q <= ST_INIT_LOAD;
                    end
                end
                ST_INIT_LOAD: begin
                    rs_q    <= 1'b0;
                    data_q  <= INIT_TABLE[init_idx_q];
                    state_q <= ST_SETUP;
                end
`endif
                default: begin
                    state_q <= RESET_STATE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
